operand_regs: RTL

Operand register stage directly upstream of the 8-bit operand multiplexer and ALU. Holds accumulator A and register B, which feed the ALU operand paths; B is the register input of the B-side operand mux, whose other input is the literal. Also latches the ALU status flags. All state updates on the rising clock edge from ALU write-back or the instruction literal, under per-register opcodes decoded by the control unit.

---
 rtl/operand_regs_pkg.sv | 19 +
 rtl/operand_regs_if.sv | 29 ++
 rtl/operand_reg.sv | 39 +++
 rtl/operand_regs.sv | 61 ++++++
 4 files changed

// File: rtl/operand_regs_pkg.sv
// Shared definitions for the operand register stage: opcodes, flag bit positions, default width.
package operand_regs_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int NFLAGS    = 4;

    typedef enum logic [1:0] {
        OP_HOLD     = 2'b00,
        OP_LOAD_ALU = 2'b01,
        OP_LOAD_LIT = 2'b10,
        OP_CLEAR    = 2'b11
    } op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/operand_regs_if.sv
// Control-unit side bundle of the operand register stage: write-back data, opcodes and register outputs.
interface operand_regs_if
    import operand_regs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0]  alu_res;
    logic [NFLAGS-1:0] alu_flags;
    logic [WIDTH-1:0]  lit;
    logic [1:0]        op_a;
    logic [1:0]        op_b;
    logic              swap;
    logic              flag_we;
    logic [WIDTH-1:0]  a_out;
    logic [WIDTH-1:0]  b_out;
    logic [NFLAGS-1:0] flags_out;

    modport master (
        output alu_res, alu_flags, lit, op_a, op_b, swap, flag_we,
        input  a_out, b_out, flags_out
    );

    modport slave (
        input  alu_res, alu_flags, lit, op_a, op_b, swap, flag_we,
        output a_out, b_out, flags_out
    );

endinterface

// File: rtl/operand_reg.sv
// One operand register: own opcode wins, else swap takes the peer's pre-edge value, else hold.
// Latency: 1 cycle; no backpressure.
module operand_reg
    import operand_regs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [WIDTH-1:0] lit,
    input  logic             swap,
    input  logic [WIDTH-1:0] peer,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = q;
        case (op_e'(op))
            OP_HOLD:     nxt = swap ? peer : q;
            OP_LOAD_ALU: nxt = alu_res;
            OP_LOAD_LIT: nxt = lit;
            OP_CLEAR:    nxt = '0;
            default:     nxt = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/operand_regs.sv
// Accumulator A / register B ahead of the ALU operand mux; flags register built only with OPERAND_REGS_STATUS_EN.
// Latency: 1 cycle, outputs straight from registers; no backpressure, the control unit owns sequencing.
module operand_regs
    import operand_regs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    operand_regs_if.slave bus
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Each register sees the other's registered value, so a swap is a clean exchange.
    operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk     (clk),
        .rst     (rst),
        .op      (bus.op_a),
        .alu_res (bus.alu_res),
        .lit     (bus.lit),
        .swap    (bus.swap),
        .peer    (b_q),
        .q       (a_q)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk     (clk),
        .rst     (rst),
        .op      (bus.op_b),
        .alu_res (bus.alu_res),
        .lit     (bus.lit),
        .swap    (bus.swap),
        .peer    (a_q),
        .q       (b_q)
    );

    assign bus.a_out = a_q;
    assign bus.b_out = b_q;

`ifdef OPERAND_REGS_STATUS_EN
    logic [NFLAGS-1:0] flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (bus.flag_we) begin
            flags_q <= bus.alu_flags;
        end
    end

    assign bus.flags_out = flags_q;
`else
    logic unused_status;

    assign unused_status = ^{bus.flag_we, bus.alu_flags};
    assign bus.flags_out = '0;
`endif

endmodule
